// File: rtl/fpu_pkg.sv
// Shared binary32 field widths, operand/pipeline payload types and unpack helpers
// for the FP alignment datapath.
package fpu_pkg;

  localparam int unsigned FP_W      = 32;
  localparam int unsigned EXP_W     = 8;
  localparam int unsigned MAN_W     = 23;
  localparam int unsigned SIG_W     = MAN_W + 1;
  localparam int unsigned SHAMT_W   = 5;
  localparam int unsigned SHAMT_MAX = 31;
  localparam int unsigned EXT_W     = 57;
  localparam int unsigned PAD_W     = EXT_W - SIG_W;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp_unpacked_t;

  // Stage 1: operands ordered by magnitude, alignment distance resolved
  typedef struct packed {
    logic               sign_big;
    logic               sign_small;
    logic [EXP_W-1:0]   exp_big;
    logic [SIG_W-1:0]   man_big;
    logic [SIG_W-1:0]   man_small;
    logic [SHAMT_W-1:0] shamt;
    logic               swapped;
  } s1_payload_t;

  typedef struct packed {
    logic               sign_big;
    logic               sign_small;
    logic [EXP_W-1:0]   exp_big;
    logic [SIG_W-1:0]   man_big;
    logic [SIG_W-1:0]   man_small_al;
    logic               guard;
    logic               round;
    logic               sticky;
    logic [SHAMT_W-1:0] shamt;
    logic               swapped;
  } s2_payload_t;

  function automatic fp_unpacked_t fp_unpack(input logic [FP_W-1:0] x);
    fp_unpacked_t u;
    u.sign = x[FP_W-1];
    u.exp  = x[FP_W-2 -: EXP_W];
    u.man  = x[MAN_W-1:0];
    return u;
  endfunction

  // Denormals share the exponent of the smallest normal
  function automatic logic [EXP_W-1:0] fp_eff_exp(input fp_unpacked_t u);
    return (u.exp == '0) ? EXP_W'(1) : u.exp;
  endfunction

  function automatic logic [SIG_W-1:0] fp_sig(input fp_unpacked_t u);
    return {(u.exp != '0), u.man};
  endfunction

endpackage

// File: rtl/fp_rshift_sticky.sv
// Combinational alignment shifter: right-shifts a significand through a zero-padded
// extension and extracts guard, round and sticky from the bits shifted out.
module fp_rshift_sticky
  import fpu_pkg::*;
(
  input  logic [SIG_W-1:0]   i_man,
  input  logic [SHAMT_W-1:0] i_shamt,
  output logic [SIG_W-1:0]   o_man_al_c,
  output logic               o_guard_c,
  output logic               o_round_c,
  output logic               o_sticky_c
);

  logic [EXT_W-1:0] w_ext;

  assign w_ext      = {i_man, PAD_W'(0)} >> i_shamt;
  assign o_man_al_c = w_ext[EXT_W-1 -: SIG_W];
  assign o_guard_c  = w_ext[PAD_W-1];
  assign o_round_c  = w_ext[PAD_W-2];
  assign o_sticky_c = |w_ext[PAD_W-3:0];

endmodule

// File: rtl/fp_align_shifter.sv
// Two-stage binary32 operand alignment: stage 1 orders operands by magnitude and
// computes the clamped shift, stage 2 registers the aligned smaller significand.
module fp_align_shifter
  import fpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FP_W-1:0]    a,
  input  logic [FP_W-1:0]    b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               sign_big,
  output logic               sign_small,
  output logic [EXP_W-1:0]   exp_big,
  output logic [SIG_W-1:0]   man_big,
  output logic [SIG_W-1:0]   man_small_al,
  output logic               guard,
  output logic               round,
  output logic               sticky,
  output logic [SHAMT_W-1:0] shamt,
  output logic               swapped
);

  fp_unpacked_t     w_a, w_b, w_big, w_small;
  logic             w_swap;
  logic [EXP_W-1:0] w_exp_big, w_exp_small, w_diff;
  s1_payload_t      w_s1_next;
  s2_payload_t      w_s2_next;
  logic             w_s2_load, w_s1_load;

  logic             r_s1_valid;
  s1_payload_t      r_s1;
  logic             r_out_valid;
  s2_payload_t      r_s2;

  // Handshake: stage 2 frees when empty or draining; stage 1 frees when stage 2 can take it
  assign w_s2_load = !r_out_valid || out_ready;
  assign w_s1_load = !r_s1_valid || w_s2_load;
  assign in_ready  = w_s1_load;

  // Unpack, magnitude compare (ties keep a as larger) and clamped distance
  always_comb begin
    w_a         = fp_unpack(a);
    w_b         = fp_unpack(b);
    w_swap      = {w_b.exp, w_b.man} > {w_a.exp, w_a.man};
    w_big       = w_swap ? w_b : w_a;
    w_small     = w_swap ? w_a : w_b;
    w_exp_big   = fp_eff_exp(w_big);
    w_exp_small = fp_eff_exp(w_small);
    w_diff      = w_exp_big - w_exp_small;

    w_s1_next            = '0;
    w_s1_next.sign_big   = w_big.sign;
    w_s1_next.sign_small = w_small.sign;
    w_s1_next.exp_big    = w_exp_big;
    w_s1_next.man_big    = fp_sig(w_big);
    w_s1_next.man_small  = fp_sig(w_small);
    w_s1_next.shamt      = (w_diff > EXP_W'(SHAMT_MAX)) ? SHAMT_W'(SHAMT_MAX)
                                                        : w_diff[SHAMT_W-1:0];
    w_s1_next.swapped    = w_swap;
  end

  fp_rshift_sticky u_rshift (
    .i_man      (r_s1.man_small),
    .i_shamt    (r_s1.shamt),
    .o_man_al_c (w_s2_next.man_small_al),
    .o_guard_c  (w_s2_next.guard),
    .o_round_c  (w_s2_next.round),
    .o_sticky_c (w_s2_next.sticky)
  );

  assign w_s2_next.sign_big   = r_s1.sign_big;
  assign w_s2_next.sign_small = r_s1.sign_small;
  assign w_s2_next.exp_big    = r_s1.exp_big;
  assign w_s2_next.man_big    = r_s1.man_big;
  assign w_s2_next.shamt      = r_s1.shamt;
  assign w_s2_next.swapped    = r_s1.swapped;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else if (w_s1_load) begin
      r_s1_valid <= in_valid;
      if (in_valid) r_s1 <= w_s1_next;
    end
  end

  // Data only reloads on a real transfer so a stalled result stays bit-stable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_s2        <= '0;
    end else if (w_s2_load) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) r_s2 <= w_s2_next;
    end
  end

  assign out_valid    = r_out_valid;
  assign sign_big     = r_s2.sign_big;
  assign sign_small   = r_s2.sign_small;
  assign exp_big      = r_s2.exp_big;
  assign man_big      = r_s2.man_big;
  assign man_small_al = r_s2.man_small_al;
  assign guard        = r_s2.guard;
  assign round        = r_s2.round;
  assign sticky       = r_s2.sticky;
  assign shamt        = r_s2.shamt;
  assign swapped      = r_s2.swapped;

endmodule

// File: tb/tb_fp_align_shifter.sv
// Scoreboard bench for fp_align_shifter: directed and random operand pairs against
// an arithmetic reference model, with backpressure and mid-flight reset.
module tb_fp_align_shifter;

  typedef struct packed {
    logic        sb;
    logic        ss;
    logic [7:0]  eb;
    logic [23:0] mb;
    logic [23:0] ms;
    logic        g;
    logic        r;
    logic        s;
    logic [4:0]  sh;
    logic        sw;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        sign_big, sign_small, guard, round, sticky, swapped;
  logic [7:0]  exp_big;
  logic [23:0] man_big, man_small_al;
  logic [4:0]  shamt;

  res_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   saw_bp = 0;
  bit   hold_low = 0;
  bit   rnd_ready = 0;
  bit   prev_stalled = 0;
  res_t prev_out;

  fp_align_shifter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .a            (a),
    .b            (b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .sign_big     (sign_big),
    .sign_small   (sign_small),
    .exp_big      (exp_big),
    .man_big      (man_big),
    .man_small_al (man_small_al),
    .guard        (guard),
    .round        (round),
    .sticky       (sticky),
    .shamt        (shamt),
    .swapped      (swapped)
  );

  always #5 clk = ~clk;

  function automatic res_t cur();
    res_t c;
    c.sb = sign_big;  c.ss = sign_small; c.eb = exp_big;
    c.mb = man_big;   c.ms = man_small_al;
    c.g  = guard;     c.r  = round;      c.s  = sticky;
    c.sh = shamt;     c.sw = swapped;
    return c;
  endfunction

  function automatic res_t mk(input logic sb, ss, input logic [7:0] eb,
                              input logic [23:0] mb, ms, input logic g, r, s,
                              input logic [4:0] sh, input logic sw);
    res_t c;
    c.sb = sb; c.ss = ss; c.eb = eb; c.mb = mb; c.ms = ms;
    c.g = g; c.r = r; c.s = s; c.sh = sh; c.sw = sw;
    return c;
  endfunction

  // Reference: integer magnitudes, integer exponent difference, 64-bit shift
  function automatic res_t model(input logic [31:0] x, input logic [31:0] y);
    res_t        res;
    logic [31:0] big, sml;
    int          eb, es, d, sh;
    longint unsigned sig_s, ext;
    res.sw = (y[30:0] > x[30:0]);
    big    = res.sw ? y : x;
    sml    = res.sw ? x : y;
    eb     = (big[30:23] == 8'd0) ? 1 : int'(big[30:23]);
    es     = (sml[30:23] == 8'd0) ? 1 : int'(sml[30:23]);
    d      = eb - es;
    sh     = (d > 31) ? 31 : d;
    res.sb = big[31];
    res.ss = sml[31];
    res.eb = 8'(eb);
    res.mb = {(big[30:23] != 8'd0), big[22:0]};
    sig_s  = 64'({(sml[30:23] != 8'd0), sml[22:0]});
    ext    = (sig_s << 33) >> sh;
    res.ms = 24'(ext >> 33);
    res.g  = ext[32];
    res.r  = ext[31];
    res.s  = (ext[30:0] != 31'd0);
    res.sh = 5'(sh);
    return res;
  endfunction

  task automatic check_bit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0b want=%0b", name, got, want);
    end
  endtask

  // Present one pair; leaves in_valid high so consecutive calls stream back-to-back
  task automatic send(input logic [31:0] xa, input logic [31:0] xb, input res_t e);
    int budget;
    budget = 0;
    @(negedge clk);
    in_valid = 1'b1; a = xa; b = xb;
    #1;
    while (!in_ready) begin
      budget++;
      if (budget > 200) begin
        checks++; errors++;
        $display("FAIL accept_timeout a=%h b=%h", xa, xb);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk); #1;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  always @(negedge clk) begin
    out_ready = hold_low ? 1'b0 : (rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
  end

  // Monitor: pops on every output transfer, and checks stalled outputs stay frozen
  always @(negedge clk) begin
    res_t got, e;
    #2;
    if (!rst_n) begin
      prev_stalled = 0;
    end else begin
      got = cur();
      if (in_valid && !in_ready) saw_bp++;
      if (prev_stalled) begin
        checks++;
        if (!out_valid || got !== prev_out) begin
          errors++;
          $display("FAIL hold_stable valid=%0b got=%h want=%h", out_valid, got, prev_out);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output got=%h want=none", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL result got=%h want=%h", got, e);
          end
        end
      end
      prev_stalled = out_valid && !out_ready;
      prev_out     = got;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] x, y;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    #1;
    check_bit("reset_out_valid", out_valid, 1'b0);
    check_bit("reset_in_ready", in_ready, 1'b1);
    checks++;
    if (cur() !== '0) begin
      errors++;
      $display("FAIL reset_data got=%h want=0", cur());
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors with hand-derived expectations
    send(32'h3F800000, 32'h3F000000, mk(0, 0, 8'd127, 24'h800000, 24'h400000, 0, 0, 0, 5'd1, 0));
    send(32'h3F000000, 32'h3F800000, mk(0, 0, 8'd127, 24'h800000, 24'h400000, 0, 0, 0, 5'd1, 1));
    send(32'h3F800000, 32'h3F800000, mk(0, 0, 8'd127, 24'h800000, 24'h800000, 0, 0, 0, 5'd0, 0));
    send(32'h4B800000, 32'h3F800001, mk(0, 0, 8'd151, 24'h800000, 24'h000000, 1, 0, 1, 5'd24, 0));
    send(32'h7F000000, 32'h3F800000, mk(0, 0, 8'd254, 24'h800000, 24'h000000, 0, 0, 1, 5'd31, 0));
    send(32'h7F000000, 32'h00000000, mk(0, 0, 8'd254, 24'h800000, 24'h000000, 0, 0, 0, 5'd31, 0));
    send(32'hBF800000, 32'h40000000, mk(0, 1, 8'd128, 24'h800000, 24'h400000, 0, 0, 0, 5'd1, 1));
    send(32'h00000003, 32'h00000001, mk(0, 0, 8'd1, 24'h000003, 24'h000001, 0, 0, 0, 5'd0, 0));
    idle();
    drain();

    // Five back-to-back pairs with a four-cycle downstream stall
    saw_bp = 0;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          x = $urandom; y = $urandom;
          send(x, y, model(x, y));
        end
        idle();
      end
      begin
        repeat (3) @(negedge clk);
        hold_low = 1;
        repeat (4) @(negedge clk);
        hold_low = 0;
      end
    join
    drain();
    checks++;
    if (saw_bp == 0) begin
      errors++;
      $display("FAIL backpressure in_ready_low_cycles=%0d want>0", saw_bp);
    end

    // Random pairs, random gaps, random downstream readiness
    rnd_ready = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        idle();
      end else begin
        x = $urandom;
        case ($urandom_range(0, 3))
          0: y = $urandom;
          1: y = x ^ ($urandom & 32'h807FFFFF);
          2: y = {1'($urandom), 8'($urandom_range(0, 2)), 23'($urandom)};
          default: y = x + ($urandom_range(0, 40) << 23);
        endcase
        if ($urandom_range(0, 1) == 1) send(y, x, model(y, x));
        else send(x, y, model(x, y));
      end
    end
    idle();
    drain();
    rnd_ready = 0;

    // Reset with two pairs in flight, then first-pair latency after release
    hold_low = 1;
    send(32'h40400000, 32'h3F800000, model(32'h40400000, 32'h3F800000));
    send(32'hC1200000, 32'h3E800000, model(32'hC1200000, 32'h3E800000));
    @(negedge clk);
    in_valid = 1'b0;
    #3;
    check_bit("pre_reset_out_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check_bit("async_reset_out_valid", out_valid, 1'b0);
    check_bit("reset_in_ready_stalled", in_ready, 1'b1);
    exp_q.delete();
    hold_low = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_bit("post_reset_idle", out_valid, 1'b0);
    in_valid = 1'b1; a = 32'h41000000; b = 32'h40000000;
    #1;
    check_bit("post_reset_in_ready", in_ready, 1'b1);
    exp_q.push_back(mk(0, 0, 8'd130, 24'h800000, 24'h200000, 0, 0, 0, 5'd2, 0));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_bit("latency_cycle1", out_valid, 1'b0);
    @(posedge clk);
    #1;
    check_bit("latency_cycle2", out_valid, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_align_shifter.md
FP_ALIGN_SHIFTER -- requirements
Module: fp_align_shifter

Interface
REQ-001 Parameter: none; all widths fixed to IEEE-754 binary32 via shared package constants.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  operand pair a/b present.
REQ-005 in_ready  output  1  block accepts pair this cycle (transfer = in_valid && in_ready).
REQ-006 a, b  input  32 each  binary32 operands.
REQ-007 out_valid  output  1  aligned result present.
REQ-008 out_ready  input  1  downstream accepts result (transfer = out_valid && out_ready).
REQ-009 sign_big, sign_small  output  1 each  signs of larger/smaller-magnitude operand.
REQ-010 exp_big  output  8  biased exponent of larger operand (effective, denormal reads as 1).
REQ-011 man_big  output  24  larger mantissa incl. hidden bit.
REQ-012 man_small_al  output  24  smaller mantissa incl. hidden bit, right-shifted by shamt.
REQ-013 guard, round, sticky  output  1 each  first, second, OR-of-remaining bits shifted out.
REQ-014 shamt  output  5  clamped alignment distance; drives the downstream sticky/select mux select (0 = no shift).
REQ-015 swapped  output  1  1 when b was larger magnitude.

Function
REQ-016 Hidden bit = (exp != 0); effective exponent = exp, or 1 when exp == 0.
REQ-017 Larger = operand with greater {exp,mantissa} magnitude; on equality a is larger, swapped = 0.
REQ-018 diff = eff_exp_big - eff_exp_small; shamt = min(diff, 31).
REQ-019 Shift on 57-bit vector {man_small, 33 zeros} >> shamt: man_small_al = bits[56:33], guard = bit 32, round = bit 31, sticky = OR bits[30:0].
REQ-020 NaN/Inf not special-cased; processed as ordinary exponent 255 values.
REQ-021 Two-stage pipeline: stage 1 registers unpack/compare/swap/shamt; stage 2 registers shift result.
REQ-022 Latency exactly 2 cycles accept-to-out_valid when unstalled; throughput 1 pair/cycle.
REQ-023 Stage 2 loads when !out_valid || out_ready; stage 1 advances into stage 2 on same condition.
REQ-024 in_ready = !s1_valid || stage-2 load condition (combinational from out_ready, no other input path).
REQ-025 While out_valid && !out_ready, all outputs held bit-stable; no input accepted once stage 1 full.
REQ-026 Simultaneous output transfer and input acceptance in one cycle loses no data, duplicates none.
REQ-027 Bubbles collapse: empty stage 2 accepts stage 1 regardless of out_ready.

Reset
REQ-028 rst_n low: s1_valid = 0, out_valid = 0 immediately (asynchronous), in_ready = 1 combinationally.
REQ-029 All data outputs reset to 0; shamt = 0; swapped = 0.
REQ-030 Reset mid-operation discards all in-flight pairs; first accept after release yields out_valid exactly 2 cycles later.

Structure
REQ-031 fpu_pkg holds EXP_W = 8, MAN_W = 23, SHAMT_W = 5, SHAMT_MAX = 31, EXT_W = 57 and a struct for the unpacked operand {sign, exp, man}.
REQ-032 One sub-module fp_rshift_sticky (combinational 57-bit right shift + guard/round/sticky extraction) instantiated in stage 2.

Verification
REQ-033 a=0x3F800000, b=0x3F000000 -> after 2 cycles: shamt=1, man_big=0x800000, man_small_al=0x400000, g/r/s=0/0/0, swapped=0.
REQ-034 a=0x3F000000, b=0x3F800000 -> swapped=1, sign_big=0, exp_big=127, shamt=1; a=b -> swapped=0, shamt=0.
REQ-035 a=0x4B800000, b=0x3F800001 -> shamt=24, man_small_al=0, guard=1, round=0, sticky=1.
REQ-036 a=0x7F000000, b=0x3F800000 -> diff 127 clamped, shamt=31, man_small_al=0, guard=0, round=0, sticky=1; b=0x00000000 -> sticky=0.
REQ-037 Stream 5 pairs back-to-back, out_ready low cycles 3-6 -> in_ready drops after stage 1 fills, outputs frozen, all 5 results delivered in order, none duplicated.
REQ-038 Assert rst_n low with 2 pairs in flight -> out_valid 0 same cycle, no stale result after release, next pair appears 2 cycles after accept.
